instr_encoder: RTL and testbench
================================

# instr_encoder

Converts decoded instruction fields (class plus register and immediate fields) back into 32-bit LEGv8 machine words for the subset the pipeline control decodes: B, B.LT, CBZ, BL, BR, ADDI, ADDS, SUBS, LDUR and STUR. Each word is tagged with a sequential byte address and buffered in a small FIFO behind a valid/ready output. The block sits between the self-test program generator and the instruction-memory write port, so benches and the boot loader can build programs from fields instead of hand-assembled hex.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- ADDR_W, 64, width of the address tag.
- BASE_ADDR, 0, address of the first emitted word.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; empties the FIFO and reloads the address counter to BASE_ADDR.
- in_valid  in  1  field set present.
- in_ready  out  1  asserted when the FIFO is not full.
- op  in  4  instruction class: 0 B, 1 B.LT, 2 CBZ, 3 BL, 4 BR, 5 ADDI, 6 ADDS, 7 SUBS, 8 LDUR, 9 STUR; 10–15 are illegal.
- rd  in  5  Rd, or Rt for CBZ, LDUR and STUR.
- rn  in  5  Rn.
- rm  in  5  Rm.
- imm  in  26  immediate, two's complement for branches and D-format; unsigned for ADDI.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  byte address of out_instr.
- err_pulse  out  1  one-cycle pulse when an accepted field set is rejected.
- err_count  out  8  count of rejected field sets; saturates at 255.

## Operation
- Accept: a field set is accepted when in_valid && in_ready at the clock edge.
- Legal set: encoded combinationally, then pushed together with the current address counter. The counter then advances by 4 and wraps modulo 2^ADDR_W.
- Rejected set: not pushed. The address counter holds, err_pulse asserts on the next cycle, and err_count increments.
- Encodings:
  - B: {000101, imm[25:0]}.
  - BL: {100101, imm[25:0]}.
  - B.LT: {01010100, imm[18:0], 01011}.
  - CBZ: {10110100, imm[18:0], rd}.
  - BR: {11010110000, 11111, 000000, rn, 00000}.
  - ADDI: {1001000100, imm[11:0], rn, rd}.
  - ADDS: {10101011000, rm, 000000, rn, rd}.
  - SUBS: {11101011000, rm, 000000, rn, rd}.
  - LDUR: {11111000010, imm[8:0], 00, rn, rd}.
  - STUR: {11111000000, imm[8:0], 00, rn, rd}.
- Unused fields are ignored. For example, rm is ignored for ADDI.
- FIFO: circular buffer with head and tail pointers plus a count. Push and pop in the same cycle leaves the count unchanged. When full, in_ready is low even if a pop occurs in that cycle; there is no full-pass-through.
- Empty: out_valid is low. out_instr and out_addr hold their last values and are don't-care.
- flush: takes priority over push and pop in the same cycle, and does not clear err_count.

## Timing
- Reset values:
  - out_valid, err_pulse and err_count are 0.
  - in_ready is 1.
  - The address counter is BASE_ADDR.
  - out_instr and out_addr are 0.
- Latency: a field set accepted at edge N into an empty FIFO gives out_valid=1 after edge N, i.e. during cycle N+1. There is no combinational path from input to output.
- Throughput: one word per cycle when out_ready stays high.
- The head is stable while out_valid && !out_ready.
- A reset or flush asserted mid-stream discards every queued word in that same edge.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - An immediate that does not fit its field is rejected.
  - Fit rules: imm[25:18] must be the sign extension of imm[18] for B.LT and CBZ; imm[25:12] must be 0 for ADDI; imm[25:9] must be the sign extension of imm[8] for LDUR and STUR.
  - Register fields are always legal.
- ENC_RANGE_CHECK_EN undefined: immediates are silently truncated to their field width, and only op values 10–15 are rejected.

## Test plan
- After reset, apply ADDI rd=1 rn=31 imm=5, then SUBS rd=3 rn=1 rm=2, with out_ready=1 -> out_instr=0x910017E1 at address 0, then 0xEB020023 at address 4.
- Apply B imm=0x3FFFFFF, B.LT imm=2, CBZ rd=5 imm=3, BR rn=30 -> out_instr = 0x17FFFFFF, 0x5400004B, 0xB4000065, 0xD61F03C0.
- Apply LDUR rd=4 rn=2 imm=8, op=15, STUR rd=4 rn=2 imm=8 -> LDUR emits 0xF8408044 at address 0. op=15 gives err_pulse for one cycle and err_count=1. STUR emits 0xF8008044 at address 4.
- With DEPTH=4 and out_ready=0, push 5 legal sets back to back -> in_ready drops after the 4th accept. Raising out_ready drains the addresses 0, 4, 8, 12 in order, then the 5th set is accepted at address 16.
- Apply ADDI rd=1 rn=31 imm=4096 -> with ENC_RANGE_CHECK_EN it is rejected and err_count=1; without it, out_instr=0x910003E1.
- Queue 3 words, then assert flush -> out_valid=0 the next cycle, and the next accepted word is tagged BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes decoded LEGv8 instruction fields into 32-bit words, tags each with a byte address and queues it in a FIFO.
// Optional macro ENC_RANGE_CHECK_EN rejects immediates that do not fit their encoding field.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [25:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [3:0] OP_B    = 4'd0;
    localparam logic [3:0] OP_BLT  = 4'd1;
    localparam logic [3:0] OP_CBZ  = 4'd2;
    localparam logic [3:0] OP_BL   = 4'd3;
    localparam logic [3:0] OP_BR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_ADDS = 4'd6;
    localparam logic [3:0] OP_SUBS = 4'd7;
    localparam logic [3:0] OP_LDUR = 4'd8;
    localparam logic [3:0] OP_STUR = 4'd9;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept;
    logic              push;
    logic              pop;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (op)
            OP_B:    enc_word = {6'b000101, imm};
            OP_BL:   enc_word = {6'b100101, imm};
            OP_BLT:  enc_word = {8'b01010100, imm[18:0], 5'b01011};
            OP_CBZ:  enc_word = {8'b10110100, imm[18:0], rd};
            OP_BR:   enc_word = {11'b11010110000, 5'b11111, 6'b000000, rn, 5'b00000};
            OP_ADDI: enc_word = {10'b1001000100, imm[11:0], rn, rd};
            OP_ADDS: enc_word = {11'b10101011000, rm, 6'b000000, rn, rd};
            OP_SUBS: enc_word = {11'b11101011000, rm, 6'b000000, rn, rd};
            OP_LDUR: enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            OP_STUR: enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            default: enc_legal = 1'b0;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        case (op)
            OP_BLT, OP_CBZ:   if (imm[25:18] != {8{imm[18]}}) enc_legal = 1'b0;
            OP_ADDI:          if (imm[25:12] != '0) enc_legal = 1'b0;
            OP_LDUR, OP_STUR: if (imm[25:9] != {17{imm[8]}}) enc_legal = 1'b0;
            default:          ;
        endcase
`endif
    end

    // Handshake: a transfer happens on a rising edge where valid && ready; the head
    // word and its address stay stable while out_valid is high and out_ready is low.
    assign in_ready  = (count != (PTR_W+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;
    assign out_instr = mem_instr[head];
    assign out_addr  = mem_addr[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            addr_cnt  <= BASE_ADDR;
            err_pulse <= 1'b0;
            err_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_addr[i]  <= '0;
            end
        end else begin
            err_pulse <= accept && !enc_legal;
            if (accept && !enc_legal && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            // Flush wins over any push or pop on the same edge.
            if (flush) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                addr_cnt <= BASE_ADDR;
            end else begin
                if (push) begin
                    mem_instr[tail] <= enc_word;
                    mem_addr[tail]  <= addr_cnt;
                    tail            <= tail + PTR_W'(1);
                    addr_cnt        <= addr_cnt + ADDR_W'(4);
                end
                if (pop)
                    head <= head + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset state, encodings, error reporting, FIFO backpressure, range handling and flush.
// Range-test expectations follow ENC_RANGE_CHECK_EN when it is defined for the build.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    // {addr, instr} pairs: expected and observed at the output handshake
    logic [95:0] exp_q[$];
    logic [95:0] got_q[$];

    logic [31:0] addi_tab [5] = '{32'h91000000, 32'h91000421, 32'h91000842,
                                  32'h91000C63, 32'h91001084};

    instr_encoder #(.DEPTH(4), .ADDR_W(64), .BASE_ADDR(64'd0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready)
            got_q.push_back({out_addr, out_instr});
    end

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd = '0; rn = '0; rm = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                        input logic [4:0] m, input logic [25:0] im);
        op = o; rd = d; rn = n; rm = m; imm = im; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++; miscompares++;
        $display("FAIL send_timeout: op=%0d never accepted, in_ready=%b required 1", o, in_ready);
    endtask

    task automatic wait_got(input int n);
        for (int k = 0; k < 100 && got_q.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        if (got_q.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++;
        if (err_pulse !== 1'b0 || err_count !== 8'd0) begin
            miscompares++; $display("FAIL reset_err: got pulse=%b count=%0d want 0/0", err_pulse, err_count);
        end
        vectors++;
        if (out_instr !== 32'd0 || out_addr !== 64'd0) begin
            miscompares++; $display("FAIL reset_out_regs: got instr=%h addr=%h want 0/0", out_instr, out_addr);
        end
    endtask

    task automatic test_alu();
        do_reset();
        out_ready = 1'b1;
        send(4'd5, 5'd1, 5'd31, 5'd0, 26'd5);
        send(4'd7, 5'd3, 5'd1, 5'd2, 26'd0);
        exp_q.push_back({64'd0, 32'h910017E1});
        exp_q.push_back({64'd4, 32'hEB020023});
        wait_got(2);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL alu_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_branches();
        do_reset();
        out_ready = 1'b1;
        send(4'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
        send(4'd1, 5'd0, 5'd0, 5'd0, 26'd2);
        send(4'd2, 5'd5, 5'd0, 5'd0, 26'd3);
        send(4'd4, 5'd0, 5'd30, 5'd0, 26'd0);
        exp_q.push_back({64'd0,  32'h17FFFFFF});
        exp_q.push_back({64'd4,  32'h5400004B});
        exp_q.push_back({64'd8,  32'hB4000065});
        exp_q.push_back({64'd12, 32'hD61F03C0});
        wait_got(4);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL branch_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mem_err();
        do_reset();
        out_ready = 1'b1;
        send(4'd8, 5'd4, 5'd2, 5'd0, 26'd8);
        send(4'd15, 5'd0, 5'd0, 5'd0, 26'd0);
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
            miscompares++; $display("FAIL err_assert: got pulse=%b count=%0d want 1/1", err_pulse, err_count);
        end
        send(4'd9, 5'd4, 5'd2, 5'd0, 26'd8);
        vectors++;
        if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
            miscompares++; $display("FAIL err_oneshot: got pulse=%b count=%0d want 0/1", err_pulse, err_count);
        end
        exp_q.push_back({64'd0, 32'hF8408044});
        exp_q.push_back({64'd4, 32'hF8008044});
        wait_got(2);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL mem_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++)
            send(4'd5, 5'(i), 5'(i), 5'd0, 26'(i));
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL full_flags: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        op = 4'd5; rd = 5'd4; rn = 5'd4; rm = 5'd0; imm = 26'd4; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || got_q.size() != 0) begin
            miscompares++; $display("FAIL full_hold: got in_ready=%b popped=%0d want 0/0", in_ready, got_q.size());
        end
        vectors++;
        if ({out_addr, out_instr} !== {64'd0, 32'h91000000}) begin
            miscompares++; $display("FAIL head_stable: got %h want %h", {out_addr, out_instr}, {64'd0, 32'h91000000});
        end
        out_ready = 1'b1;
        send(4'd5, 5'd4, 5'd4, 5'd0, 26'd4);
        for (int i = 0; i < 5; i++)
            exp_q.push_back({64'(4 * i), addi_tab[i]});
        wait_got(5);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_range();
        do_reset();
        out_ready = 1'b1;
        send(4'd5, 5'd1, 5'd31, 5'd0, 26'd4096);
`ifdef ENC_RANGE_CHECK_EN
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 0 || err_count !== 8'd1) begin
            miscompares++; $display("FAIL range_reject: got words=%0d err_count=%0d want 0/1", got_q.size(), err_count);
        end
`else
        exp_q.push_back({64'd0, 32'h910003E1});
        wait_got(1);
        vectors++;
        if (got_q.size() < 1 || got_q[0] !== exp_q[0] || err_count !== 8'd0) begin
            miscompares++; $display("FAIL range_truncate: got %h err_count=%0d want %h/0", got_q[0], err_count, exp_q[0]);
        end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++)
            send(4'd5, 5'(i), 5'(i), 5'd0, 26'(i));
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_flush_valid: got %b want 1", out_valid); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_empty: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        send(4'd5, 5'd1, 5'd1, 5'd0, 26'd1);
        exp_q.push_back({64'd0, 32'h91000421});
        wait_got(1);
        vectors++;
        if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
            miscompares++; $display("FAIL flush_base_addr: got %h want %h", got_q[0], exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branches();
        test_mem_err();
        test_back_to_back();
        test_range();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
